// File: rtl/latq_rf_pkg.sv
// latq_rf_pkg
// Shared definitions for the latch-based register file latq_rf.
//   WIDTH_MAX, DEPTH_MAX : legal upper limits of the WIDTH / DEPTH parameters
//   word_t               : widest possible storage word, a template that
//                          instances narrow to their own WIDTH
//   addr_in_range()      : true when an address selects an existing word
// Optional feature macro used elsewhere in this slice: LATQ_RF_ARRAY_CLEAR_EN.
package latq_rf_pkg;

    localparam int WIDTH_MAX = 64;
    localparam int DEPTH_MAX = 256;

    typedef logic [WIDTH_MAX-1:0] word_t;

    // Non-power-of-two depths leave address codes with no word behind them.
    function automatic logic addr_in_range(input int addr, input int depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/latq_rf_if.sv
// latq_rf_if
// Write/read port bundle of latq_rf. Clock and reset are not part of it.
//   WE, WA, D : write enable, write address, write data   (master -> slave)
//   RE, RA    : read enable, read address                  (master -> slave)
//   Q, QV     : registered read data and its valid flag    (slave -> master)
interface latq_rf_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             WE;
    logic [AW-1:0]    WA;
    logic [WIDTH-1:0] D;
    logic             RE;
    logic [AW-1:0]    RA;
    logic [WIDTH-1:0] Q;
    logic             QV;

    modport master (output WE, WA, D, RE, RA, input Q, QV);
    modport slave  (input WE, WA, D, RE, RA, output Q, QV);

endinterface

// File: rtl/latq_rf_cg.sv
// latq_rf_cg
// Integrated clock gate producing one word's latch enable.
//   CLK    : clock
//   RN     : asynchronous active-low reset, kills the enable at once
//   i_en   : raw word select, settles while CLK is high
//   o_gate : glitch-free enable, high only in the CLK-low phase
module latq_rf_cg
    import latq_rf_pkg::*;
(
    input  logic CLK,
    input  logic RN,
    input  logic i_en,
    output logic o_gate
);

    logic r_enL;

    // Enable latch is open while CLK is high so i_en can settle after the
    // rising edge, then holds steady through the whole low phase. Reset
    // clears it so a write in flight is aborted immediately.
    always_latch begin
        if (!RN)
            r_enL <= 1'b0;
        else if (CLK)
            r_enL <= i_en;
    end

    // r_enL is stable whenever ~CLK is high, so the AND cannot glitch.
    assign o_gate = ~CLK & r_enL;

endmodule

// File: rtl/latq_rf.sv
// latq_rf
// Latch-based register file: DEPTH words of WIDTH bits, one flop-staged
// write port and one registered read port, single clock domain.
//   CLK : clock; flops capture on the rise, array latches open while low
//   RN  : asynchronous active-low reset
//   bus : latq_rf_if slave (WE/WA/D write, RE/RA read, Q/QV result)
// Macro LATQ_RF_ARRAY_CLEAR_EN: when defined, RN=0 also clears all words.
module latq_rf
    import latq_rf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input logic      CLK,
    input logic      RN,
    latq_rf_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic                         r_weQ;
    logic [AW-1:0]                r_waQ;
    logic [WIDTH-1:0]             r_dQ;
    logic [WIDTH-1:0]             r_q;
    logic                         r_qv;
    logic [DEPTH-1:0][WIDTH-1:0]  w_rdArr;

    // Write stage: capture the request so the array sees stable address and
    // data for the whole following low phase. Out-of-range writes are simply
    // not captured, so no word enable can fire for them.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_weQ <= 1'b0;
            r_waQ <= '0;
            r_dQ  <= '0;
        end else if (bus.WE && addr_in_range(int'(bus.WA), DEPTH)) begin
            r_weQ <= 1'b1;
            r_waQ <= bus.WA;
            r_dQ  <= bus.D;
        end else begin
            r_weQ <= 1'b0;
        end
    end

    // Storage: one clock-gated latch word per entry. The word is transparent
    // in the low phase after the capturing edge and closed at the next rise,
    // so a read sampled on that rise already sees the new value.
    for (genvar i = 0; i < DEPTH; i++) begin : gWord
        logic             w_sel;
        logic             w_wordEn;
        logic [WIDTH-1:0] r_word;

        assign w_sel = r_weQ && (r_waQ == AW'(i));

        latq_rf_cg uCg (
            .CLK    (CLK),
            .RN     (RN),
            .i_en   (w_sel),
            .o_gate (w_wordEn)
        );

`ifdef LATQ_RF_ARRAY_CLEAR_EN
        // Reset wipes the word so post-reset reads return zero.
        always_latch begin
            if (!RN)
                r_word <= '0;
            else if (w_wordEn)
                r_word <= r_dQ;
        end
`else
        // Word keeps its contents across reset; only the enable is killed.
        always_latch begin
            if (w_wordEn)
                r_word <= r_dQ;
        end
`endif

        assign w_rdArr[i] = r_word;
    end

    // Read stage: an out-of-range address still returns a valid zero word so
    // the requester never stalls waiting for QV.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_q  <= '0;
            r_qv <= 1'b0;
        end else if (bus.RE) begin
            r_qv <= 1'b1;
            if (addr_in_range(int'(bus.RA), DEPTH))
                r_q <= w_rdArr[bus.RA];
            else
                r_q <= '0;
        end else begin
            r_qv <= 1'b0;
        end
    end

    assign bus.Q  = r_q;
    assign bus.QV = r_qv;

endmodule
